// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder (decoder_n2m_seq).
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } dec_state_t;

   localparam int unsigned MAX_OUT_W   = 64;
   localparam int unsigned DEF_DWELL   = 1;
   localparam int unsigned DWELL_CNT_W = $clog2(DEF_DWELL + 1);

   // Dwell counter width for a given DWELL value.
   function automatic int unsigned dwell_cnt_w(input int unsigned dwell);
      return $clog2(dwell + 1);
   endfunction

   // One-hot of idx, masked to the low 'width' bits.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [5:0] idx,
                                                   input int unsigned width);
      logic [MAX_OUT_W-1:0] mask;
      mask = (width >= MAX_OUT_W) ? '1 : ((64'(1) << width) - 64'(1));
      return (64'(1) << idx) & mask;
   endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Clear/enable dwell counter; tick_c flags the terminal count DWELL-1.
module dec_dwell_cnt
   import decoder_pkg::*;
#(
   parameter int unsigned DWELL = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned        CNT_W = dwell_cnt_w(DWELL);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;

   assign tick_c = en & (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/decoder_n2m_seq.sv
// Registered SEL_W-to-2^SEL_W decoder with valid/ready intake and a SCAN walk mode.
// Optional ONE_COLD_OUT_EN makes y active-low one-cold (idle value all-ones).
module decoder_n2m_seq
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 2,
   parameter int unsigned DWELL = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_mode,
   output logic [(1<<SEL_W)-1:0]   y,
   output logic                    out_valid,
   output logic                    scan_done
);

   localparam int unsigned      OUT_W    = 1 << SEL_W;
   localparam int unsigned      LAP_W    = SEL_W + 1;
   localparam logic [LAP_W-1:0] LAST_POS = LAP_W'(OUT_W - 1);
`ifdef ONE_COLD_OUT_EN
   localparam logic [OUT_W-1:0] Y_OFF    = '1;
`else
   localparam logic [OUT_W-1:0] Y_OFF    = '0;
`endif

   // Output encoding of an active position.
   function automatic logic [OUT_W-1:0] y_code(input logic [SEL_W-1:0] i);
      logic [OUT_W-1:0] oh;
      oh = OUT_W'(onehot(6'(i), OUT_W));
`ifdef ONE_COLD_OUT_EN
      return ~oh;
`else
      return oh;
`endif
   endfunction

   dec_state_t       state;
   logic [SEL_W-1:0] idx;
   logic [LAP_W-1:0] lap;
   logic             accept;
   logic             dwell_clr;
   logic             dwell_en;
   logic             dwell_tick;

   assign in_ready  = ~en_n & (state != SCAN);
   assign accept    = in_valid & in_ready;
   // Counter only runs while actively scanning; disable clears it on the same edge.
   assign dwell_clr = en_n | (state != SCAN);
   assign dwell_en  = ~dwell_clr;

   dec_dwell_cnt #(.DWELL(DWELL)) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (dwell_clr),
      .en     (dwell_en),
      .tick_c (dwell_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         lap       <= '0;
         y         <= Y_OFF;
         out_valid <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         if (en_n) begin
            state     <= IDLE;
            lap       <= '0;
            y         <= Y_OFF;
            out_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE, HOLD: begin
                  if (accept) begin
                     idx       <= in_sel;
                     lap       <= '0;
                     y         <= y_code(in_sel);
                     out_valid <= 1'b1;
                     state     <= in_mode ? SCAN : HOLD;
                  end
               end
               SCAN: begin
                  // Advance at dwell end; the last lap position retires the scan.
                  if (dwell_tick) begin
                     if (lap == LAST_POS) begin
                        state     <= IDLE;
                        lap       <= '0;
                        y         <= Y_OFF;
                        out_valid <= 1'b0;
                        scan_done <= 1'b1;
                     end else begin
                        idx <= SEL_W'(idx + SEL_W'(1));
                        lap <= LAP_W'(lap + LAP_W'(1));
                        y   <= y_code(SEL_W'(idx + SEL_W'(1)));
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decoder_n2m_seq.sv
// Self-checking bench for decoder_n2m_seq: a timeline model checked every cycle plus literal checks.
module tb_decoder_n2m_seq;

   logic clk = 1'b0;
   logic rst_n;

   logic       en_n_a, valid_a, mode_a, ready_a, ov_a, sd_a;
   logic [1:0] sel_a;
   logic [3:0] y_a;
   logic       en_n_b, valid_b, mode_b, ready_b, ov_b, sd_b;
   logic [2:0] sel_b;
   logic [7:0] y_b;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   decoder_n2m_seq #(.SEL_W(2), .DWELL(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .en_n(en_n_a), .in_valid(valid_a), .in_ready(ready_a),
      .in_sel(sel_a), .in_mode(mode_a), .y(y_a), .out_valid(ov_a), .scan_done(sd_a));

   decoder_n2m_seq #(.SEL_W(3), .DWELL(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en_n(en_n_b), .in_valid(valid_b), .in_ready(ready_b),
      .in_sel(sel_b), .in_mode(mode_b), .y(y_b), .out_valid(ov_b), .scan_done(sd_b));

   // Model: per instance, 0 = idle, 1 = holding 'start', 2 = scanning from 'start' for t cycles.
   int ow[2] = '{4, 8};
   int dw[2] = '{2, 1};
   int m_busy[2]  = '{0, 0};
   int m_start[2] = '{0, 0};
   int m_t[2]     = '{0, 0};
   int m_done[2]  = '{0, 0};

   function automatic logic [63:0] enc(input logic [63:0] oh, input int w);
      logic [63:0] mask;
      mask = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
`ifdef ONE_COLD_OUT_EN
      return ~oh & mask;
`else
      return oh & mask;
`endif
   endfunction

   function automatic logic [63:0] exp_y(input int k);
      logic [63:0] oh;
      oh = '0;
      if (m_busy[k] == 1) oh = 64'(1) << m_start[k];
      if (m_busy[k] == 2) oh = 64'(1) << ((m_start[k] + m_t[k] / dw[k]) % ow[k]);
      return enc(oh, ow[k]);
   endfunction

   task automatic mstep(input int k, input logic en_n, input logic v, input logic md, input int sel);
      if (en_n !== 1'b0) begin
         m_busy[k] = 0;
         m_done[k] = 0;
      end else if (m_busy[k] == 2) begin
         m_t[k]++;
         m_done[k] = 0;
         if (m_t[k] == ow[k] * dw[k]) begin
            m_busy[k] = 0;
            m_done[k] = 1;
         end
      end else begin
         m_done[k] = 0;
         if (v === 1'b1) begin
            m_start[k] = sel;
            m_t[k]     = 0;
            m_busy[k]  = md ? 2 : 1;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_start[k] = 0; m_t[k] = 0; m_done[k] = 0;
         end
      end else begin
         mstep(0, en_n_a, valid_a, mode_a, int'(sel_a));
         mstep(1, en_n_b, valid_b, mode_b, int'(sel_b));
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("cmp_y_a",     64'(y_a),     exp_y(0));
      check("cmp_valid_a", 64'(ov_a),    64'(m_busy[0] != 0));
      check("cmp_done_a",  64'(sd_a),    64'(m_done[0] != 0));
      check("cmp_ready_a", 64'(ready_a), 64'((en_n_a === 1'b0) && (m_busy[0] != 2)));
      check("cmp_y_b",     64'(y_b),     exp_y(1));
      check("cmp_valid_b", 64'(ov_b),    64'(m_busy[1] != 0));
      check("cmp_done_b",  64'(sd_b),    64'(m_done[1] != 0));
      check("cmp_ready_b", 64'(ready_b), 64'((en_n_b === 1'b0) && (m_busy[1] != 2)));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] t2[4] = '{64'h1, 64'h2, 64'h4, 64'h8};
   logic [63:0] t3[8] = '{64'h4, 64'h4, 64'h8, 64'h8, 64'h1, 64'h1, 64'h2, 64'h2};
   logic [63:0] t6[8] = '{64'h80, 64'h01, 64'h02, 64'h04, 64'h08, 64'h10, 64'h20, 64'h40};

   initial begin
      rst_n = 1'b0;
      en_n_a = 1'b1; valid_a = 1'b0; sel_a = 'x; mode_a = 1'b0;
      en_n_b = 1'b1; valid_b = 1'b0; sel_b = 'x; mode_b = 1'b0;

      // Reset with decoder disabled and select undefined
      repeat (2) step();
      check("rst_y_a",     64'(y_a),     enc(64'h0, 4));
      check("rst_valid_a", 64'(ov_a),    64'h0);
      check("rst_ready_a", 64'(ready_a), 64'h0);
      check("rst_y_b",     64'(y_b),     enc(64'h0, 8));
      rst_n = 1'b1;
      step();

      // DIRECT back-to-back accepts, then hold
      en_n_a = 1'b0; mode_a = 1'b0; valid_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sel_a = 2'(k);
         step();
         check("direct_y", 64'(y_a), enc(t2[k], 4));
      end
      valid_a = 1'b0;
      repeat (2) step();
      check("hold_y", 64'(y_a), enc(64'h8, 4));

      // SCAN from 2 with DWELL=2, wrapping; in_valid during scan is ignored
      sel_a = 2'd2; mode_a = 1'b1; valid_a = 1'b1;
      step();
      valid_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("scan_y", 64'(y_a), enc(t3[i], 4));
         check("scan_ready", 64'(ready_a), 64'h0);
         if (i == 3) begin valid_a = 1'b1; mode_a = 1'b0; sel_a = 2'd1; end
         if (i == 5) valid_a = 1'b0;
         step();
      end
      check("scan_done", 64'(sd_a), 64'h1);
      check("scan_end_y", 64'(y_a), enc(64'h0, 4));
      check("scan_end_ready", 64'(ready_a), 64'h1);
      step();
      check("scan_done_pulse", 64'(sd_a), 64'h0);

      // Abort a scan at its third cycle, then recover with a DIRECT accept
      sel_a = 2'd0; mode_a = 1'b1; valid_a = 1'b1;
      step();
      valid_a = 1'b0;
      repeat (2) step();
      en_n_a = 1'b1;
      step();
      check("abort_y", 64'(y_a), enc(64'h0, 4));
      check("abort_valid", 64'(ov_a), 64'h0);
      step();
      check("abort_no_done", 64'(sd_a), 64'h0);
      en_n_a = 1'b0;
      #1;
      check("resume_ready", 64'(ready_a), 64'h1);
      sel_a = 2'd3; mode_a = 1'b0; valid_a = 1'b1;
      step();
      valid_a = 1'b0;
      check("resume_y", 64'(y_a), enc(64'h8, 4));

      // Disabled with in_valid high and in_sel undefined
      en_n_a = 1'b1; valid_a = 1'b1; sel_a = 'x;
      repeat (5) begin
         step();
         check("dis_y", 64'(y_a), enc(64'h0, 4));
         check("dis_ready", 64'(ready_a), 64'h0);
      end
      valid_a = 1'b0; sel_a = 2'd0; en_n_a = 1'b0;

      // SEL_W=3, DWELL=1 scan from 7
      en_n_b = 1'b0; sel_b = 3'd7; mode_b = 1'b1; valid_b = 1'b1;
      step();
      valid_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("sweep_y", 64'(y_b), enc(t6[i], 8));
         step();
      end
      check("sweep_done", 64'(sd_b), 64'h1);
      check("sweep_end_y", 64'(y_b), enc(64'h0, 8));

      // Reset asserted mid-scan
      sel_b = 3'd1; mode_b = 1'b1; valid_b = 1'b1;
      step();
      valid_b = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_y", 64'(y_b), enc(64'h0, 8));
      check("rst_mid_valid", 64'(ov_b), 64'h0);
      check("rst_mid_done", 64'(sd_b), 64'h0);
      step();
      rst_n = 1'b1;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
